display_timings_prog: RTL and testbench

- Runtime-programmable successor to the fixed-parameter display timing generator.
- Produces beam coordinates, sync, display-enable, frame and line strobes for any mode loaded over a valid/ready config port.
- New timings are held in shadow registers and applied only at a frame boundary, so the monitor never sees a torn frame.
- Sync and DE can be delayed by a parametrised pipeline depth to match downstream pixel-pipeline latency.

---
 rtl/display_timings_prog.sv | 252 +++++++++++++++++++++++++
 tb/tb_display_timings_prog.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_timings_prog.sv
`default_nettype none
// ============================================================================
// Module   : display_timings_prog
// Brief    : Runtime-programmable display timing generator. Emits beam
//            coordinates, sync, display-enable, frame and line strobes for a
//            mode loaded over a valid/ready config port. New timings wait in
//            a shadow register and take effect only at a frame boundary.
//            Sync and DE can be delayed by PIPE extra register stages.
// Revision : 1.0 - initial release
// ============================================================================
module display_timings_prog #(
  parameter int CORDW  = 16,
  parameter int FCW    = 16,
  parameter int PIPE   = 0,
  parameter int H_RES  = 800,
  parameter int H_FP   = 40,
  parameter int H_SYNC = 128,
  parameter int H_BP   = 88,
  parameter int V_RES  = 600,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 4,
  parameter int V_BP   = 23,
  parameter int H_POL  = 1,
  parameter int V_POL  = 1
) (
  input  logic                    i_pix_clk,
  input  logic                    i_rst,
  input  logic                    i_cfg_valid,
  output logic                    o_cfg_ready,
  input  logic [CORDW-2:0]        i_h_res,
  input  logic [CORDW-2:0]        i_h_fp,
  input  logic [CORDW-2:0]        i_h_sync,
  input  logic [CORDW-2:0]        i_h_bp,
  input  logic [CORDW-2:0]        i_v_res,
  input  logic [CORDW-2:0]        i_v_fp,
  input  logic [CORDW-2:0]        i_v_sync,
  input  logic [CORDW-2:0]        i_v_bp,
  input  logic                    i_h_pol,
  input  logic                    i_v_pol,
  output logic                    o_cfg_err,
  output logic                    o_hs,
  output logic                    o_vs,
  output logic                    o_de,
  output logic                    o_frame,
  output logic                    o_line,
  output logic signed [CORDW-1:0] o_sx,
  output logic signed [CORDW-1:0] o_sy,
  output logic [FCW-1:0]          o_frame_cnt
);

  localparam int FW = CORDW - 1;

  // Per-axis timing in the form the counters consume directly: start value,
  // sync window (inclusive), last active coordinate and sync polarity.
  typedef struct packed {
    logic signed [CORDW-1:0] sta;
    logic signed [CORDW-1:0] sbeg;
    logic signed [CORDW-1:0] send;
    logic signed [CORDW-1:0] aend;
    logic                    pol;
  } axis_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } cfg_state_t;

  // Inactive {hs, vs, de} for the reset-default mode.
  localparam logic [2:0] OUT_IDLE = {H_POL == 0, V_POL == 0, 1'b0};

  // Turns raw porch/sync/active fields into counter boundaries.
  function automatic axis_t derive(input logic [FW-1:0] res,
                                   input logic [FW-1:0] fp,
                                   input logic [FW-1:0] sync,
                                   input logic [FW-1:0] bp,
                                   input logic          pol);
    axis_t            a;
    logic [CORDW-1:0] blank;
    blank  = {1'b0, fp} + {1'b0, sync} + {1'b0, bp};
    a.sta  = $signed(-blank);
    a.sbeg = $signed(a.sta) + $signed({1'b0, fp});
    a.send = $signed(a.sbeg) + $signed({1'b0, sync}) - $signed(CORDW'(1));
    a.aend = $signed({1'b0, res}) - $signed(CORDW'(1));
    a.pol  = pol;
    return a;
  endfunction

  axis_t h_def;
  axis_t v_def;
  assign h_def = derive(FW'(H_RES), FW'(H_FP), FW'(H_SYNC), FW'(H_BP), H_POL != 0);
  assign v_def = derive(FW'(V_RES), FW'(V_FP), FW'(V_SYNC), FW'(V_BP), V_POL != 0);

  cfg_state_t              state_q;
  cfg_state_t              state_d;
  axis_t                   h_q;
  axis_t                   v_q;
  axis_t                   h_shd_q;
  axis_t                   v_shd_q;
  axis_t                   h_nxt;
  axis_t                   v_nxt;
  logic signed [CORDW-1:0] sx_q;
  logic signed [CORDW-1:0] sx_d;
  logic signed [CORDW-1:0] sy_q;
  logic signed [CORDW-1:0] sy_d;
  logic                    frame_q;
  logic                    frame_d;
  logic                    line_q;
  logic                    line_d;
  logic                    err_q;
  logic                    err_d;
  logic                    cap;
  logic                    apply;
  logic                    line_end;
  logic                    frame_end;
  logic                    hs_act;
  logic                    vs_act;
  logic [2:0]              out_q;
  logic [2:0]              out_d;
  logic [FCW-1:0]          fcnt_q;

  // Beam advance; at a pending frame end the next coordinates and strobes are
  // evaluated against the shadow mode so the switch is frame-aligned.
  always_comb begin
    line_end  = (sx_q == h_q.aend);
    frame_end = line_end && (sy_q == v_q.aend);
    apply     = (state_q == ST_PENDING) && frame_end;
    h_nxt     = apply ? h_shd_q : h_q;
    v_nxt     = apply ? v_shd_q : v_q;
    sx_d      = sx_q + CORDW'(1);
    sy_d      = sy_q;
    if (line_end) begin
      sx_d = h_nxt.sta;
      sy_d = frame_end ? v_nxt.sta : sy_q + CORDW'(1);
    end
    line_d  = (sx_d == h_nxt.sta);
    frame_d = line_d && (sy_d == v_nxt.sta);
    hs_act  = ($signed(sx_d) >= $signed(h_nxt.sbeg)) && ($signed(sx_d) <= $signed(h_nxt.send));
    vs_act  = ($signed(sy_d) >= $signed(v_nxt.sbeg)) && ($signed(sy_d) <= $signed(v_nxt.send));
    out_d   = {hs_act ~^ h_nxt.pol, vs_act ~^ v_nxt.pol, ~sx_d[CORDW-1] & ~sy_d[CORDW-1]};
  end

  // Config handshake: reject degenerate modes, otherwise hold until frame end.
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cfg_valid) begin
          if ((i_h_res == '0) || (i_v_res == '0) || (i_h_sync == '0) || (i_v_sync == '0)) begin
            err_d = 1'b1;
          end else begin
            cap     = 1'b1;
            state_d = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (frame_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Config FSM state register.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shadow register: captures the offered mode in already-derived form.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      h_shd_q <= '0;
      v_shd_q <= '0;
    end else if (cap) begin
      h_shd_q <= derive(i_h_res, i_h_fp, i_h_sync, i_h_bp, i_h_pol);
      v_shd_q <= derive(i_v_res, i_v_fp, i_v_sync, i_v_bp, i_v_pol);
    end
  end

  // Active mode: defaults after reset, replaced only on the applying frame end.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      h_q <= h_def;
      v_q <= v_def;
    end else if (apply) begin
      h_q <= h_shd_q;
      v_q <= v_shd_q;
    end
  end

  // Beam counters, strobes, undelayed sync/DE, frame counter and error pulse.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      sx_q    <= h_def.sta;
      sy_q    <= v_def.sta;
      frame_q <= 1'b1;
      line_q  <= 1'b1;
      out_q   <= OUT_IDLE;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      frame_q <= frame_d;
      line_q  <= line_d;
      out_q   <= out_d;
      fcnt_q  <= fcnt_q + FCW'(frame_end);
      err_q   <= err_d;
    end
  end

  generate
    if (PIPE == 0) begin : g_nopipe
      assign {o_hs, o_vs, o_de} = out_q;
    end else begin : g_pipe
      logic [2:0] stage_q [PIPE];

      // Delay line matching downstream pixel-pipeline latency.
      always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
          for (int i = 0; i < PIPE; i++) begin
            stage_q[i] <= OUT_IDLE;
          end
        end else begin
          stage_q[0] <= out_q;
          for (int i = 1; i < PIPE; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign {o_hs, o_vs, o_de} = stage_q[PIPE-1];
    end
  endgenerate

  assign o_cfg_ready = (state_q == ST_IDLE);
  assign o_cfg_err   = err_q;
  assign o_frame     = frame_q;
  assign o_line      = line_q;
  assign o_sx        = sx_q;
  assign o_sy        = sy_q;
  assign o_frame_cnt = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_display_timings_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_timings_prog
// Brief    : Directed self-checking bench for display_timings_prog. One
//            instance uses the full reset-default mode (single line checked),
//            two use a small default mode (PIPE=0 and PIPE=3) for whole
//            frames, mode switches, rejects and reset while pending.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_timings_prog;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic [14:0] h_res, h_fp, h_sync, h_bp, v_res, v_fp, v_sync, v_bp;
  logic        h_pol, v_pol;

  logic               d_rdy, d_err, d_hs, d_vs, d_de, d_frame, d_line;
  logic signed [15:0] d_sx, d_sy;
  logic [15:0]        d_fcnt;
  logic               s_rdy, s_err, s_hs, s_vs, s_de, s_frame, s_line;
  logic signed [15:0] s_sx, s_sy;
  logic [15:0]        s_fcnt;
  logic               p_rdy, p_err, p_hs, p_vs, p_de, p_frame, p_line;
  logic signed [15:0] p_sx, p_sy;
  logic [15:0]        p_fcnt;

  int n_total = 0;
  int n_bad   = 0;

  int m_len, m_de, m_hs, m_vs, m_ln, m_rdy0, m_err;
  int f_hs, f_vs, f_de, fp_hs, fp_vs, fp_de;

  display_timings_prog dut_d (
    .i_pix_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .o_cfg_ready(d_rdy),
    .i_h_res(h_res), .i_h_fp(h_fp), .i_h_sync(h_sync), .i_h_bp(h_bp),
    .i_v_res(v_res), .i_v_fp(v_fp), .i_v_sync(v_sync), .i_v_bp(v_bp),
    .i_h_pol(h_pol), .i_v_pol(v_pol), .o_cfg_err(d_err),
    .o_hs(d_hs), .o_vs(d_vs), .o_de(d_de), .o_frame(d_frame), .o_line(d_line),
    .o_sx(d_sx), .o_sy(d_sy), .o_frame_cnt(d_fcnt)
  );

  display_timings_prog #(
    .PIPE(0), .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_RES(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .H_POL(1), .V_POL(0)
  ) dut_s (
    .i_pix_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .o_cfg_ready(s_rdy),
    .i_h_res(h_res), .i_h_fp(h_fp), .i_h_sync(h_sync), .i_h_bp(h_bp),
    .i_v_res(v_res), .i_v_fp(v_fp), .i_v_sync(v_sync), .i_v_bp(v_bp),
    .i_h_pol(h_pol), .i_v_pol(v_pol), .o_cfg_err(s_err),
    .o_hs(s_hs), .o_vs(s_vs), .o_de(s_de), .o_frame(s_frame), .o_line(s_line),
    .o_sx(s_sx), .o_sy(s_sy), .o_frame_cnt(s_fcnt)
  );

  display_timings_prog #(
    .PIPE(3), .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_RES(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .H_POL(1), .V_POL(0)
  ) dut_p (
    .i_pix_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .o_cfg_ready(p_rdy),
    .i_h_res(h_res), .i_h_fp(h_fp), .i_h_sync(h_sync), .i_h_bp(h_bp),
    .i_v_res(v_res), .i_v_fp(v_fp), .i_v_sync(v_sync), .i_v_bp(v_bp),
    .i_h_pol(h_pol), .i_v_pol(v_pol), .o_cfg_err(p_err),
    .o_hs(p_hs), .o_vs(p_vs), .o_de(p_de), .o_frame(p_frame), .o_line(p_line),
    .o_sx(p_sx), .o_sy(p_sy), .o_frame_cnt(p_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cfg(input int hr, input int hf, input int hs, input int hb,
                         input int vr, input int vf, input int vs, input int vb,
                         input int hp, input int vp);
    h_res  = 15'(hr); h_fp = 15'(hf); h_sync = 15'(hs); h_bp = 15'(hb);
    v_res  = 15'(vr); v_fp = 15'(vf); v_sync = 15'(vs); v_bp = 15'(vb);
    h_pol  = (hp != 0);
    v_pol  = (vp != 0);
  endtask

  // Runs the small instances from a frame-start sample to the next one,
  // offering the current config fields at sample index offer_at.
  task automatic measure(input int offer_at);
    m_len = 0; m_de = 0; m_hs = 0; m_vs = 0; m_ln = 0; m_rdy0 = 0; m_err = 0;
    f_hs = -1; f_vs = -1; f_de = -1; fp_hs = -1; fp_vs = -1; fp_de = -1;
    for (int n = 0; n < 4000; n++) begin
      if (s_de) m_de++;
      if (s_hs) m_hs++;
      if (s_vs) m_vs++;
      if (s_line) m_ln++;
      if (!s_rdy) m_rdy0++;
      if (s_err) m_err++;
      if (s_hs && f_hs < 0) f_hs = n;
      if (!s_vs && f_vs < 0) f_vs = n;
      if (s_de && f_de < 0) f_de = n;
      if (p_hs && fp_hs < 0) fp_hs = n;
      if (!p_vs && fp_vs < 0) fp_vs = n;
      if (p_de && fp_de < 0) fp_de = n;
      cfg_valid = (n == offer_at);
      tick();
      if (s_frame) begin
        m_len = n + 1;
        break;
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_first_sx;
    int hs_n;
    int len;

    rst = 1'b1;
    cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    // Full default mode: reset state and one complete line.
    chk("d_sx_rst", d_sx, -256);
    chk("d_sy_rst", d_sy, -28);
    chk("d_frame_rst", d_frame, 1);
    chk("d_line_rst", d_line, 1);
    chk("d_de_rst", d_de, 0);
    chk("d_hs_rst", d_hs, 0);
    chk("d_vs_rst", d_vs, 0);
    chk("d_fcnt_rst", d_fcnt, 0);
    chk("d_rdy_rst", d_rdy, 1);
    chk("d_err_rst", d_err, 0);

    hs_first_sx = 9999;
    hs_n = 0;
    len = 0;
    for (int n = 0; n < 2000; n++) begin
      if (d_hs && hs_first_sx == 9999) hs_first_sx = d_sx;
      if (d_hs) hs_n++;
      tick();
      if (d_line) begin
        len = n + 1;
        break;
      end
    end
    chk("d_line_len", len, 1056);
    chk("d_hs_start_sx", hs_first_sx, -216);
    chk("d_hs_width", hs_n, 128);
    chk("d_sy_line2", d_sy, -27);
    chk("d_frame_line2", d_frame, 0);

    // Small mode: H 16/2/3/4 (sta -9), V 6/1/2/3 (sta -6), hs pol 1, vs pol 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s_sx_rst", s_sx, -9);
    chk("s_sy_rst", s_sy, -6);
    chk("s_frame_rst", s_frame, 1);
    chk("s_line_rst", s_line, 1);
    chk("s_hs_rst", s_hs, 0);
    chk("s_vs_rst", s_vs, 1);
    chk("s_de_rst", s_de, 0);
    chk("s_fcnt_rst", s_fcnt, 0);
    chk("s_rdy_rst", s_rdy, 1);
    chk("s_err_rst", s_err, 0);
    chk("p_hs_rst", p_hs, 0);
    chk("p_vs_rst", p_vs, 1);
    chk("p_de_rst", p_de, 0);
    chk("p_sx_rst", p_sx, -9);
    chk("p_sy_rst", p_sy, -6);
    chk("p_frame_rst", p_frame, 1);
    chk("p_line_rst", p_line, 1);
    chk("p_fcnt_rst", p_fcnt, 0);
    chk("p_rdy_rst", p_rdy, 1);
    chk("p_err_rst", p_err, 0);

    // Default frame; mid-frame offer of mode 8/1/2/3 x 4/1/1/2, pol 0/0.
    set_cfg(8, 1, 2, 3, 4, 1, 1, 2, 0, 0);
    measure(50);
    chk("m1_len", m_len, 300);
    chk("m1_de", m_de, 96);
    chk("m1_hs_high", m_hs, 36);
    chk("m1_vs_high", m_vs, 250);
    chk("m1_lines", m_ln, 12);
    chk("m1_rdy_low", m_rdy0, 249);
    chk("m1_err", m_err, 0);
    chk("m1_hs_first", f_hs, 2);
    chk("m1_vs_first", f_vs, 25);
    chk("m1_de_first", f_de, 159);
    chk("p3_hs_first", fp_hs, 5);
    chk("p3_vs_first", fp_vs, 28);
    chk("p3_de_first", fp_de, 162);
    chk("m2_start_sx", s_sx, -6);
    chk("m2_start_sy", s_sy, -4);
    chk("m2_start_rdy", s_rdy, 1);
    chk("m2_start_hs", s_hs, 1);
    chk("fcnt_1", s_fcnt, 1);

    // Rejected offer (h_sync=0) during the new mode.
    set_cfg(8, 1, 0, 3, 4, 1, 1, 2, 0, 0);
    measure(10);
    chk("m2_len", m_len, 112);
    chk("m2_err_pulses", m_err, 1);
    chk("m2_rdy_low", m_rdy0, 0);
    chk("m2_de", m_de, 32);
    chk("m2_hs_high", m_hs, 96);
    chk("m2_vs_high", m_vs, 98);
    chk("m2_lines", m_ln, 8);
    chk("fcnt_2", s_fcnt, 2);

    // Offer 4/1/1/1 x 3/1/1/1 pol 1/1 exactly on the frame-end cycle.
    set_cfg(4, 1, 1, 1, 3, 1, 1, 1, 1, 1);
    measure(111);
    chk("fe_len", m_len, 112);
    chk("fe_rdy_low", m_rdy0, 0);
    chk("fe_rdy_after", s_rdy, 0);
    chk("fe_sx_kept", s_sx, -6);
    chk("fe_sy_kept", s_sy, -4);
    chk("fcnt_3", s_fcnt, 3);

    // A second offer while pending must be ignored.
    set_cfg(5, 1, 1, 1, 3, 1, 1, 1, 1, 1);
    measure(5);
    chk("pend_len", m_len, 112);
    chk("pend_rdy_low", m_rdy0, 112);
    chk("m3_start_sx", s_sx, -3);
    chk("m3_start_sy", s_sy, -3);
    chk("m3_start_rdy", s_rdy, 1);
    chk("fcnt_4", s_fcnt, 4);

    measure(-1);
    chk("m3_len", m_len, 42);
    chk("m3_de", m_de, 12);
    chk("m3_hs_high", m_hs, 6);
    chk("m3_vs_high", m_vs, 7);
    chk("m3_lines", m_ln, 6);

    // Reset while a config is pending.
    set_cfg(8, 1, 2, 3, 4, 1, 1, 2, 0, 0);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    chk("rp_rdy_pending", s_rdy, 0);
    chk("rp_sy_pending", s_sy, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rp_sx", s_sx, -9);
    chk("rp_sy", s_sy, -6);
    chk("rp_rdy", s_rdy, 1);
    chk("rp_fcnt", s_fcnt, 0);
    measure(-1);
    chk("rp_len", m_len, 300);
    chk("rp_next_sx", s_sx, -9);
    chk("rp_next_sy", s_sy, -6);
    chk("rp_fcnt_1", s_fcnt, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
